rd_data_checker: RTL and testbench
==================================

# rd_data_checker

Downstream consumer of the read-side FIFO in the DDR3 test path. It pulls words out of a standard (non-first-word-fall-through) FIFO, where `dout` is valid one cycle after `rd_en`. Each word is compared against the incrementing pattern produced by the test-data generator, and the block reports pass/fail, an error count and the first mismatch. It sits between the read FIFO and the board status LEDs/debug probes.

## Interface
- `DATA_WIDTH`, 16: FIFO data width.
- `TEST_LEN`, 256: words checked per run, range 1..65535.
- `START_VAL`, 0: expected value of word 0.
- `TIMEOUT`, 4096: idle cycles without `rd_valid` before a run aborts.
- `clk` input 1: single clock, shared with the FIFO.
- `rst_n` input 1: asynchronous, active-low reset.
- `calib_done` input 1: DDR3 calibration complete.
- `start` input 1: single-cycle request to begin a run.
- `rd_valid` input 1: FIFO not empty.
- `rd_data` input DATA_WIDTH: FIFO `dout`.
- `rd_en` output 1: FIFO read enable.
- `busy` output 1: run in progress.
- `done` output 1: run finished; held until the next accepted `start`.
- `pass` output 1: qualified by `done`. 1 means all words matched and there was no timeout.
- `timeout` output 1: the run aborted on `TIMEOUT`.
- `err_cnt` output 16: mismatch count, saturates at 0xFFFF.
- `first_err_idx` output 16: index of the first mismatched word.
- `first_err_data` output DATA_WIDTH: received value at the first mismatch.

## Operation
- The state machine has four states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - `start` is accepted only when `calib_done` is 1.
  - On acceptance, clear all counters and flags and move to READ.
  - A `start` with `calib_done` at 0 is ignored.
- READ:
  - `rd_en = rd_valid && (issued < TEST_LEN)`, and is combinational from state.
  - Each `rd_en` increments `issued`.
  - When the last read is issued (`issued` becomes TEST_LEN), move to DRAIN.
- Compare stage:
  - `cmp_vld` is `rd_en` registered by one cycle.
  - When `cmp_vld` is 1, compare `rd_data` against `expected`, then `expected <= expected + 1`. The addition wraps modulo 2^DATA_WIDTH.
  - On a mismatch, `err_cnt` increments (saturating).
  - If this is the first mismatch, latch `first_err_idx` (the compare index) and `first_err_data`.
- DRAIN: lasts one cycle, which completes the final compare. Then move to DONE with `pass = (err_cnt == 0)`, where `err_cnt` includes that final compare.
- Timeout:
  - In READ, a counter increments on every cycle with `rd_valid = 0` and is cleared whenever `rd_en` is 1.
  - When it reaches TIMEOUT, set `timeout` to 1 and `pass` to 0, and go to DONE. Any compare still in flight is discarded.
- DONE:
  - Outputs hold.
  - An accepted `start` restarts the run exactly as from IDLE.
- `start` while `busy` is ignored.
- `busy` is 1 in READ and DRAIN.

## Timing
- Reset values: state IDLE. `rd_en`, `busy`, `done`, `pass` and `timeout` are 0. `err_cnt`, `first_err_idx` and `first_err_data` are 0. `expected` is START_VAL.
- `start` accepted at cycle 0 → READ at cycle 1 → earliest `rd_en` at cycle 1.
- Back-to-back `rd_valid` gives one read per cycle.
- `done` rises 2 cycles after the last `rd_en`: one cycle for DRAIN, one for the transition into DONE.
- Minimum run length is TEST_LEN + 3 cycles from `start`.
- Reset asserted mid-run: all state clears immediately and asynchronously. No further `rd_en` is issued.
- `TEST_LEN = 1`: a single read, then DRAIN, then DONE.

## Structure
- Shared package `ddr3_test_pkg` holds:
  - the state encoding (IDLE/READ/DRAIN/DONE);
  - `DATA_WIDTH`;
  - the pattern step constant (+1), also used by the test-data generator.
- One sub-module, `rd_timeout_cnt`: a loadable idle counter with a terminal flag.
- Everything else stays flat in `rd_data_checker`.

## Test plan
- Clean run: `TEST_LEN = 256`; the FIFO is preloaded with 0..255 and held non-empty → `done = 1`, `pass = 1`, `err_cnt = 0`, `done` 2 cycles after the 256th `rd_en`.
- Single corruption: word 5 = 0x1234 → `err_cnt = 1`, `first_err_idx = 5`, `first_err_data = 0x1234`, `pass = 0`.
- Bursty FIFO:
  - `rd_valid` toggles 1/0 every 3 cycles.
  - `rd_en` is never 1 while `rd_valid` is 0.
  - Result is `pass = 1` with exactly 256 reads.
- Timeout:
  - `TIMEOUT = 16`; `rd_valid` drops permanently after 100 words.
  - `timeout = 1`, `pass = 0`, `done = 1` exactly 16 cycles after the last `rd_en`.
- Gating and reset:
  - `start` with `calib_done = 0` → stays IDLE.
  - `rst_n` pulled low at word 50 → all outputs return to reset values at once.
  - A new `start` after reset → clean `pass = 1`.
- Wrap: `START_VAL = 0xFFF0`, `TEST_LEN = 32`, data 0xFFF0..0x000F → `pass = 1`.

Source files
------------

// File: rtl/ddr3_test_pkg.sv
// Shared definitions for the DDR3 test path: checker state encoding,
// default data width and the pattern step used by generator and checker.
package ddr3_test_pkg;

    localparam int DATA_WIDTH = 16;

    // The test-data generator emits START, START+PAT_STEP, ... (wrapping).
    localparam int PAT_STEP = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_t;

endpackage

// File: rtl/rd_timeout_cnt.sv
// Loadable idle counter with a terminal flag. The counter reloads to 1 on
// activity so that an abort lands exactly TERM cycles after the last read.
module rd_timeout_cnt #(
    parameter int TERM = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic inc,
    output logic tc
);

    localparam int CNT_W = $clog2(TERM + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(1);
    localparam logic [CNT_W-1:0] TERM_M1  = CNT_W'(TERM - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0] cnt;

    // Terminal when this idle cycle completes the TERM-cycle window.
    assign tc = inc && !load && (cnt >= TERM_M1);

    // Reload on activity, otherwise count idle cycles (saturating).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= LOAD_VAL;
        else if (load)
            cnt <= LOAD_VAL;
        else if (inc && cnt != CNT_MAX)
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/rd_data_checker.sv
// Read-FIFO consumer: pulls TEST_LEN words from a standard FIFO (dout one
// cycle after rd_en), checks them against the incrementing test pattern and
// reports pass/fail, error count, first mismatch and idle timeout.
module rd_data_checker #(
    parameter int                    DATA_WIDTH = ddr3_test_pkg::DATA_WIDTH,
    parameter int                    TEST_LEN   = 256,
    parameter logic [DATA_WIDTH-1:0] START_VAL  = '0,
    parameter int                    TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  calib_done,
    input  logic                  start,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_en,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [15:0]           err_cnt,
    output logic [15:0]           first_err_idx,
    output logic [DATA_WIDTH-1:0] first_err_data
);

    import ddr3_test_pkg::*;

    localparam logic [15:0]           LEN16  = 16'(TEST_LEN);
    localparam logic [15:0]           LEN_M1 = 16'(TEST_LEN - 1);
    localparam logic [DATA_WIDTH-1:0] STEP   = DATA_WIDTH'(PAT_STEP);

    chk_state_t            state;
    logic [15:0]           issued;
    logic [15:0]           cmp_idx;
    logic [DATA_WIDTH-1:0] expected;
    logic                  cmp_vld;
    logic                  cmp_en;
    logic                  mism;
    logic [15:0]           err_nxt;
    logic                  tmo_hit;
    logic                  accept;

    assign accept = start && calib_done && (state == ST_IDLE || state == ST_DONE);
    assign rd_en  = (state == ST_READ) && rd_valid && (issued < LEN16);

    rd_timeout_cnt #(.TERM(TIMEOUT)) u_tmo (
        .clk   (clk),
        .rst_n (rst_n),
        .load  ((state != ST_READ) || rd_en),
        .inc   (!rd_valid),
        .tc    (tmo_hit)
    );

    // Compare qualification and next error count; an abort drops the
    // in-flight compare.
    always_comb begin
        cmp_en  = cmp_vld && (state == ST_READ || state == ST_DRAIN) && !tmo_hit;
        mism    = cmp_en && (rd_data != expected);
        err_nxt = err_cnt;
        if (mism && err_cnt != 16'hFFFF)
            err_nxt = err_cnt + 16'd1;
    end

    // Run control: state plus registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state   <= ST_READ;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                        timeout <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (tmo_hit) begin
                        state   <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        timeout <= 1'b1;
                    end else if (rd_en && issued == LEN_M1) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_nxt == 16'd0);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read issue count, compare pipeline and mismatch capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued         <= '0;
            cmp_idx        <= '0;
            cmp_vld        <= 1'b0;
            expected       <= START_VAL;
            err_cnt        <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
        end else if (accept) begin
            issued         <= '0;
            cmp_idx        <= '0;
            cmp_vld        <= 1'b0;
            expected       <= START_VAL;
            err_cnt        <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
        end else begin
            cmp_vld <= rd_en;
            if (rd_en)
                issued <= issued + 16'd1;
            if (cmp_en) begin
                expected <= expected + STEP;
                cmp_idx  <= cmp_idx + 16'd1;
                err_cnt  <= err_nxt;
                if (mism && err_cnt == 16'd0) begin
                    first_err_idx  <= cmp_idx;
                    first_err_data <= rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_rd_data_checker.sv
// Scoreboard bench for rd_data_checker: a queue-based FIFO model feeds the
// DUT, a per-run result model is pushed on start and checked when done rises.
module tb_rd_data_checker;

    localparam int          DW  = 16;
    localparam int          LEN = 256;
    localparam int          TMO = 16;
    localparam logic [15:0] SV  = 16'hFFF0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          calib_done = 1'b0;
    logic          start = 1'b0;
    logic          rd_valid = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic          rd_en, busy, done, pass, timeout;
    logic [15:0]   err_cnt, first_err_idx;
    logic [DW-1:0] first_err_data;

    rd_data_checker #(
        .DATA_WIDTH (DW),
        .TEST_LEN   (LEN),
        .START_VAL  (SV),
        .TIMEOUT    (TMO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .calib_done     (calib_done),
        .start          (start),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .rd_en          (rd_en),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout),
        .err_cnt        (err_cnt),
        .first_err_idx  (first_err_idx),
        .first_err_data (first_err_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit pass;
        bit tmo;
        int errs;
        int fidx;
        int fdata;
        int reads;
        int lat;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] fifo_q[$];
    int            vectors = 0;
    int            miscompares = 0;
    int            n_reads = 0;
    int            last_rd = 0;
    bit            run_done = 0;
    bit            done_q = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, note whether the DUT reads, and present
    // the popped word as FIFO dout just after the edge.
    task automatic tick(input bit st, input bit gate);
        bit pop;
        @(negedge clk);
        start    = st;
        rd_valid = gate && (fifo_q.size() > 0);
        #1;
        pop = rd_en;
        if (rd_en) begin
            chk("rd_en_needs_valid", int'(rd_valid), 1);
            n_reads++;
            last_rd = cyc;
        end
        @(posedge clk);
        #1;
        if (pop && fifo_q.size() > 0)
            rd_data = fifo_q.pop_front();
    endtask

    // Monitor: every rising done retires one scoreboard entry.
    always @(negedge clk) begin : mon
        exp_t e;
        if (done && !done_q) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("pass",           int'(pass),           int'(e.pass));
                chk("timeout",        int'(timeout),        int'(e.tmo));
                chk("err_cnt",        int'(err_cnt),        e.errs);
                chk("first_err_idx",  int'(first_err_idx),  e.fidx);
                chk("first_err_data", int'(first_err_data), e.fdata);
                chk("read_count",     n_reads,              e.reads);
                chk("done_latency",   cyc - last_rd,        e.lat);
            end
            run_done = 1;
        end
        done_q = done;
    end

    // mode: 0 FIFO always ready, 1 bursty 3-on/3-off, 2 random gaps.
    task automatic run_case(input int n_words, input int mode, input int ncorrupt,
                            input int fixed_idx, input bit mid_start, input int reset_at);
        logic [15:0] d[];
        exp_t        e;
        int          c;
        int          idx;
        bit          g;
        d = new[n_words];
        for (int i = 0; i < n_words; i++) d[i] = SV + 16'(i);
        if (fixed_idx >= 0) d[fixed_idx] = 16'h1234;
        for (int k = 0; k < ncorrupt; k++) begin
            idx = $urandom_range(0, n_words - 1);
            d[idx] = d[idx] ^ 16'($urandom_range(1, 65535));
        end
        // Reference: word i should equal START + i mod 2^16.
        e.errs = 0; e.fidx = 0; e.fdata = 0;
        for (int i = 0; i < n_words; i++) begin
            if (d[i] != 16'(int'(SV) + i)) begin
                if (e.errs == 0) begin
                    e.fidx  = i;
                    e.fdata = int'(d[i]);
                end
                e.errs++;
            end
        end
        e.tmo   = (n_words < LEN);
        e.pass  = !e.tmo && (e.errs == 0);
        e.reads = n_words;
        e.lat   = e.tmo ? TMO : 2;
        fifo_q.delete();
        for (int i = 0; i < n_words; i++) fifo_q.push_back(d[i]);
        if (reset_at < 0) sb.push_back(e);
        n_reads  = 0;
        run_done = 0;
        tick(1'b1, 1'b1);
        c = 0;
        while (!run_done && c < 3000) begin
            g = (mode == 0) ? 1'b1 : (mode == 1) ? ((c / 3) % 2 == 0) : ($urandom_range(0, 3) != 0);
            tick(mid_start && c == 40, g);
            c++;
            if (reset_at >= 0 && n_reads == reset_at) break;
        end
        if (reset_at >= 0) begin
            rst_n = 1'b0;
            #1;
            chk("rst_rd_en",          int'(rd_en),          0);
            chk("rst_busy",           int'(busy),           0);
            chk("rst_done",           int'(done),           0);
            chk("rst_pass",           int'(pass),           0);
            chk("rst_timeout",        int'(timeout),        0);
            chk("rst_err_cnt",        int'(err_cnt),        0);
            chk("rst_first_err_idx",  int'(first_err_idx),  0);
            chk("rst_first_err_data", int'(first_err_data), 0);
            repeat (3) tick(1'b0, 1'b1);
            chk("no_reads_in_reset", n_reads, reset_at);
            @(negedge clk);
            rst_n = 1'b1;
            fifo_q.delete();
        end else if (!run_done) begin
            vectors++;
            miscompares++;
            $display("FAIL run_budget: done not seen after %0d cycles", c);
            sb.delete();
        end else begin
            repeat (3) tick(1'b0, 1'b0);
            chk("done_held", int'(done), 1);
            chk("pass_held", int'(pass), int'(e.pass));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset_rd_en",          int'(rd_en),          0);
        chk("reset_busy",           int'(busy),           0);
        chk("reset_done",           int'(done),           0);
        chk("reset_pass",           int'(pass),           0);
        chk("reset_timeout",        int'(timeout),        0);
        chk("reset_err_cnt",        int'(err_cnt),        0);
        chk("reset_first_err_idx",  int'(first_err_idx),  0);
        chk("reset_first_err_data", int'(first_err_data), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // start without calibration must be ignored
        calib_done = 1'b0;
        tick(1'b1, 1'b0);
        repeat (3) tick(1'b0, 1'b0);
        chk("gated_busy", int'(busy), 0);
        chk("gated_done", int'(done), 0);
        calib_done = 1'b1;

        run_case(LEN, 0, 0, -1, 1'b0, -1);   // clean, back-to-back, wraps FFFF->0
        run_case(LEN, 0, 0,  5, 1'b0, -1);   // word 5 = 0x1234
        run_case(LEN, 1, 0, -1, 1'b0, -1);   // bursty FIFO
        run_case(LEN, 2, 3, -1, 1'b1, -1);   // random gaps, corruptions, start while busy
        run_case(100, 0, 0, -1, 1'b0, -1);   // FIFO runs dry -> timeout
        run_case(LEN, 0, 0, 10, 1'b0, 50);   // reset at word 50
        run_case(LEN, 0, 0, -1, 1'b0, -1);   // clean run after reset
        for (int r = 0; r < 3; r++)
            run_case(LEN, 2, $urandom_range(0, 4), -1, 1'b0, -1);

        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_leftover: %0d entries", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
